// File: rtl/counter_pkg.sv
// Shared types and constants for the counter sequencer and its prescaler.
package counter_pkg;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned OP_W  = 2;
  localparam int unsigned ST_W  = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_HOLD = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [OP_W-1:0] OP_SET_LIMIT = 2'd0;
  localparam logic [OP_W-1:0] OP_START     = 2'd1;
  localparam logic [OP_W-1:0] OP_PAUSE     = 2'd2;
  localparam logic [OP_W-1:0] OP_STOP      = 2'd3;

endpackage

// File: rtl/counter_prescaler.sv
// Programmable tick divider: one tick every prescale+1 cycles while run is high.
module counter_prescaler #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               clr,
  input  logic [PRESC_W-1:0] prescale,
  output logic               tick
);

  logic [PRESC_W-1:0] pre_cnt_q;
  logic [PRESC_W-1:0] pre_cnt_d;

  assign tick = run & (pre_cnt_q == prescale);

  // Count holds whenever run is low, so a paused count resumes where it left off.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clr) begin
      pre_cnt_d = '0;
    end else if (run) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven sequencer for the 8-bit counter datapath: load, prescaled
// increment, terminal-count detection with optional auto-reload.
module counter_sequencer
  import counter_pkg::*;
#(
  parameter int unsigned     PRESC_W     = 8,
  parameter logic [CNT_W-1:0] RESET_LIMIT = 8'hFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [OP_W-1:0]    cmd_op,
  input  logic [CNT_W-1:0]   cmd_data,
  input  logic               auto_reload,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [CNT_W-1:0]   cnt_q,
  output logic               cnt_load,
  output logic [CNT_W-1:0]   cnt_load_val,
  output logic               cnt_inc,
  output logic               busy,
  output logic               done,
  output logic [ST_W-1:0]    state_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [CNT_W-1:0] start_q, start_d;

  logic accept, is_set, is_start, is_pause, is_stop, ctrl_win;
  logic run, clr, tick, tick_ok, match;

  assign cmd_ready = ena & (state_q != ST_LOAD);
  assign accept    = cmd_valid & cmd_ready;
  assign is_set    = accept & (cmd_op == OP_SET_LIMIT);
  assign is_start  = accept & (cmd_op == OP_START);
  assign is_stop   = accept & (cmd_op == OP_STOP);
  assign is_pause  = accept & (cmd_op == OP_PAUSE) &
                     ((state_q == ST_RUN) | (state_q == ST_HOLD));

  // Control commands take priority over a coincident tick.
  assign ctrl_win = is_start | is_pause | is_stop;
  assign run      = ena & (state_q == ST_RUN);
  assign clr      = (state_q == ST_LOAD) | is_stop;
  assign tick_ok  = tick & ~ctrl_win;
  assign match    = (cnt_q == limit_q);

  counter_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .clr      (clr),
    .prescale (prescale),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      limit_q <= RESET_LIMIT;
      start_q <= '0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    limit_d = is_set ? cmd_data : limit_q;
    start_d = is_start ? cmd_data : start_q;
    if (is_stop) begin
      state_d = ST_IDLE;
    end else if (is_start) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: if (ena) state_d = ST_RUN;
        ST_RUN: begin
          if (is_pause) begin
            state_d = ST_HOLD;
          end else if (tick_ok & match & ~auto_reload) begin
            state_d = ST_DONE;
          end
        end
        ST_HOLD: if (is_pause) state_d = ST_RUN;
        default: state_d = state_q;
      endcase
    end
  end

  // Mealy strobes; gated by ena so a frozen block drives nothing.
  always_comb begin
    cnt_load     = ena & ((state_q == ST_LOAD) | (tick_ok & match & auto_reload));
    cnt_inc      = tick_ok & ~match;
    done         = tick_ok & match;
    cnt_load_val = cnt_load ? start_q : '0;
    busy         = (state_q == ST_LOAD) | (state_q == ST_RUN) | (state_q == ST_HOLD);
    state_o      = ST_W'(state_q);
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: cycle reference model plus latency-formula checks.
module tb_counter_sequencer;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, ena, cmd_valid, auto_reload;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data, prescale;
  logic [7:0] cnt_q = 8'd0;
  logic       cmd_ready, cnt_load, cnt_inc, busy, done;
  logic [7:0] cnt_load_val;
  logic [2:0] state_o;

  int n_cmp, n_bad, cyc_n, k_start, last_dut_done, n_dut_done, n_low;
  int m_state, m_limit, m_start, m_pre;

  always #5 clk = ~clk;

  counter_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .auto_reload  (auto_reload),
    .prescale     (prescale),
    .cnt_q        (cnt_q),
    .cnt_load     (cnt_load),
    .cnt_load_val (cnt_load_val),
    .cnt_inc      (cnt_inc),
    .busy         (busy),
    .done         (done),
    .state_o      (state_o)
  );

  // Counter register of the datapath, driven by the sequencer's strobes.
  always @(posedge clk) begin
    if (cnt_load) cnt_q <= cnt_load_val;
    else if (cnt_inc) cnt_q <= cnt_q + 8'd1;
  end

  function automatic int exp_lat(input int s, input int l, input int p);
    return 1 + ((((l - s) % 256) + 256) % 256 + 1) * (p + 1);
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc_n + 1);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc_n + 1);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_limit = 255;
    m_start = 0;
    m_pre   = 0;
  endtask

  // One clock: drive, check against model, advance model across the edge.
  task automatic step(input logic v, input logic [1:0] op, input logic [7:0] d);
    bit   acc, win, tk, mt;
    logic e_ready, e_load, e_inc, e_done, e_busy;
    logic [7:0] e_val;
    cmd_valid = v;
    cmd_op    = op;
    cmd_data  = d;
    #1;
    e_ready = ena && (m_state != 1);
    acc     = v && e_ready;
    win     = acc && (op == OP_START || op == OP_STOP ||
                      (op == OP_PAUSE && (m_state == 2 || m_state == 3)));
    tk      = ena && (m_state == 2) && (m_pre == int'(prescale));
    mt      = (int'(cnt_q) == m_limit);
    e_done  = tk && !win && mt;
    e_inc   = tk && !win && !mt;
    e_load  = ena && ((m_state == 1) || (e_done && auto_reload));
    e_val   = e_load ? 8'(m_start) : 8'd0;
    e_busy  = (m_state >= 1) && (m_state <= 3);

    chk8("state_o", state_o, 8'(m_state));
    chk1("cmd_ready", cmd_ready, e_ready);
    chk1("busy", busy, e_busy);
    chk1("cnt_load", cnt_load, e_load);
    chk8("cnt_load_val", cnt_load_val, e_val);
    chk1("cnt_inc", cnt_inc, e_inc);
    chk1("done", done, e_done);

    if (done === 1'b1) begin
      last_dut_done = cyc_n + 1;
      n_dut_done++;
    end
    if (acc && op == OP_START) k_start = cyc_n + 1;

    if (acc && op == OP_SET_LIMIT) m_limit = int'(d);
    if (acc && op == OP_STOP) begin
      m_state = 0;
      m_pre   = 0;
    end else if (acc && op == OP_START) begin
      m_state = 1;
      m_start = int'(d);
    end else if (m_state == 1) begin
      if (ena) m_state = 2;
      m_pre = 0;
    end else if (m_state == 2 && ena) begin
      m_pre = tk ? 0 : (m_pre + 1) % 256;
      if (acc && op == OP_PAUSE) m_state = 3;
      else if (e_done && !auto_reload) m_state = 4;
    end else if (m_state == 3 && acc && op == OP_PAUSE) begin
      m_state = 2;
    end

    @(posedge clk);
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget, input bit rnd_ena);
    last_dut_done = -1;
    n_low = 0;
    for (int i = 0; i < budget && last_dut_done < 0; i++) begin
      ena = rnd_ena ? ($urandom_range(0, 7) != 0) : 1'b1;
      if (!ena) n_low++;
      step(1'b0, OP_SET_LIMIT, 8'd0);
    end
    ena = 1'b1;
    n_cmp++;
    assert (last_dut_done >= 0) else begin
      n_bad++;
      $error("FAIL done_timeout: observed no done within %0d cycles, required a done pulse", budget);
    end
  endtask

  initial begin
    int s, l, p, guard;
    n_cmp = 0; n_bad = 0; cyc_n = 0; k_start = 0;
    last_dut_done = -1; n_dut_done = 0; n_low = 0;
    rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0;
    cmd_data = 8'd0; auto_reload = 1'b0; prescale = 8'd0;
    model_reset();
    @(negedge clk);
    step(1'b0, OP_SET_LIMIT, 8'd0);
    rst_n = 1'b1;

    // Default limit is 0xFF after reset.
    step(1'b1, OP_START, 8'd250);
    wait_done(50, 1'b0);
    chk_i("lat_default_limit", last_dut_done - k_start, exp_lat(250, 255, 0));

    // Basic count S=3 L=5 P=0.
    step(1'b1, OP_SET_LIMIT, 8'd5);
    step(1'b1, OP_START, 8'd3);
    wait_done(50, 1'b0);
    chk_i("lat_s3_l5", last_dut_done - k_start, 4);
    step(1'b0, OP_SET_LIMIT, 8'd0);
    step(1'b0, OP_SET_LIMIT, 8'd0);
    chk8("done_state_held", state_o, 8'd4);
    chk8("done_cnt_held", cnt_q, 8'd5);

    // Asynchronous reset in the middle of a run.
    step(1'b1, OP_SET_LIMIT, 8'd9);
    step(1'b1, OP_START, 8'd100);
    step(1'b0, OP_SET_LIMIT, 8'd0);
    step(1'b0, OP_SET_LIMIT, 8'd0);
    step(1'b0, OP_SET_LIMIT, 8'd0);
    #1;
    chk1("pre_reset_inc", cnt_inc, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk8("rst_state", state_o, 8'd0);
    chk1("rst_load", cnt_load, 1'b0);
    chk1("rst_inc", cnt_inc, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, OP_START, 8'd250);
    wait_done(50, 1'b0);
    chk_i("lat_limit_after_reset", last_dut_done - k_start, 7);

    // Prescale 2, S=0, L=1.
    prescale = 8'd2;
    step(1'b1, OP_SET_LIMIT, 8'd1);
    step(1'b1, OP_START, 8'd0);
    wait_done(50, 1'b0);
    chk_i("lat_presc2", last_dut_done - k_start, 7);

    // Auto-reload S=10 L=12 P=0.
    prescale = 8'd0;
    auto_reload = 1'b1;
    step(1'b1, OP_SET_LIMIT, 8'd12);
    step(1'b1, OP_START, 8'd10);
    n_dut_done = 0;
    for (int i = 0; i < 12; i++) step(1'b0, OP_SET_LIMIT, 8'd0);
    chk_i("auto_done_count", n_dut_done, 3);
    chk1("auto_busy", busy, 1'b1);
    step(1'b1, OP_STOP, 8'd0);
    chk8("auto_stop_state", state_o, 8'd0);
    chk1("auto_stop_busy", busy, 1'b0);
    auto_reload = 1'b0;

    // Wrap through 255 -> 0.
    step(1'b1, OP_SET_LIMIT, 8'd1);
    step(1'b1, OP_START, 8'd254);
    wait_done(50, 1'b0);
    chk_i("lat_wrap", last_dut_done - k_start, 5);

    // PAUSE colliding with a tick, then resume.
    prescale = 8'd1;
    step(1'b1, OP_SET_LIMIT, 8'd3);
    step(1'b1, OP_START, 8'd0);
    guard = 0;
    while (!(m_state == 2 && m_pre == int'(prescale)) && guard < 20) begin
      step(1'b0, OP_SET_LIMIT, 8'd0);
      guard++;
    end
    chk_i("pause_found_tick", guard < 20 ? 1 : 0, 1);
    step(1'b1, OP_PAUSE, 8'd0);
    chk8("pause_state", state_o, 8'd3);
    for (int i = 0; i < 3; i++) step(1'b0, OP_SET_LIMIT, 8'd0);
    step(1'b1, OP_PAUSE, 8'd0);
    wait_done(100, 1'b0);
    chk8("pause_final_cnt", cnt_q, 8'd3);

    // ena low for 4 RUN cycles delays done by 4.
    prescale = 8'd0;
    step(1'b1, OP_SET_LIMIT, 8'd5);
    step(1'b1, OP_START, 8'd0);
    step(1'b0, OP_SET_LIMIT, 8'd0);
    step(1'b0, OP_SET_LIMIT, 8'd0);
    ena = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, OP_STOP, 8'd0);
    ena = 1'b1;
    wait_done(50, 1'b0);
    chk_i("lat_ena_gap", last_dut_done - k_start, exp_lat(0, 5, 0) + 4);

    // Random start/limit/prescale with random enable gaps.
    for (int it = 0; it < 25; it++) begin
      s = int'($urandom_range(0, 255));
      l = (s + int'($urandom_range(0, 15))) % 256;
      p = int'($urandom_range(0, 3));
      prescale = 8'(p);
      step(1'b1, OP_SET_LIMIT, 8'(l));
      step(1'b1, OP_START, 8'(s));
      wait_done(2000, 1'b1);
      chk_i("lat_random", last_dut_done - k_start, exp_lat(s, l, p) + n_low);
    end

    // Unconstrained random command traffic.
    for (int it = 0; it < 400; it++) begin
      if (it % 50 == 0) prescale = 8'($urandom_range(0, 2));
      if (it % 37 == 0) auto_reload = 1'($urandom_range(0, 1));
      ena = ($urandom_range(0, 9) != 0);
      step(1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
           8'($urandom_range(0, 255)));
    end
    ena = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Controller that sequences the team's 8-bit counter datapath.
- Accepts commands over a valid/ready interface: set limit, start, pause/resume, stop.
- Drives the counter's load and increment strobes through a programmable prescaler.
- Reports terminal-count completion.
- Sits between the ui_in-decoded command logic and the counter register inside the tt_um top.

Parameters:
PRESC_W, 8, width of prescale divisor input (tick period = prescale+1 clocks)
RESET_LIMIT, 8'hFF, limit register value after reset

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
ena  input  1  design enable; low freezes the block
cmd_valid  input  1  command valid
cmd_ready  output  1  command ready
cmd_op  input  2  opcode: 0 SET_LIMIT, 1 START, 2 PAUSE (toggle), 3 STOP
cmd_data  input  8  limit value (SET_LIMIT) or start value (START); ignored otherwise
auto_reload  input  1  1 = reload start value on match and keep running
prescale  input  PRESC_W  tick divisor, sampled every cycle
cnt_q  input  8  current counter value from datapath
cnt_load  output  1  load strobe to counter
cnt_load_val  output  8  value to load
cnt_inc  output  1  increment strobe; datapath wraps 255->0
busy  output  1  high in LOAD, RUN, HOLD
done  output  1  one-cycle pulse on terminal match
state_o  output  3  current state encoding

Behaviour:
- Single clock domain. Reset is asynchronous, active-low, using clk/rst_n.
- Reset state:
  - state = IDLE; limit_r = RESET_LIMIT; start_r = 0; pre_cnt = 0.
  - cnt_load, cnt_inc, done, busy = 0; cnt_load_val = 0.
- States (state_o encoding): IDLE=0, LOAD=1, RUN=2, HOLD=3, DONE=4.
- cmd_ready = ena & (state != LOAD), combinational. A command is accepted when cmd_valid & cmd_ready.
- SET_LIMIT:
  - limit_r <= cmd_data in any state where accepted; no state change.
  - A compare in the same cycle uses the old limit.
- START: accepted in IDLE, RUN, HOLD or DONE.
  - start_r <= cmd_data; next state LOAD.
  - Restarts a running count.
- LOAD:
  - Lasts exactly one cycle: cnt_load=1, cnt_load_val=start_r.
  - Then RUN with pre_cnt=0.
- PAUSE: RUN->HOLD, HOLD->RUN; ignored in IDLE/DONE.
  - pre_cnt holds in HOLD and is not cleared.
- STOP: any accepted state -> IDLE; pre_cnt cleared; no strobes that cycle.
- RUN, prescaler:
  - If pre_cnt == prescale: tick = 1 and pre_cnt <= 0.
  - Otherwise pre_cnt increments.
- Tick handling:
  - If cnt_q == limit_r: done=1.
    - auto_reload=1: cnt_load=1 with cnt_load_val=start_r; stay RUN.
    - auto_reload=0: -> DONE, no cnt_inc.
  - Else cnt_inc=1.
- Timing with start S, limit L, prescale P, START accepted at edge k:
  - LOAD cycle is k+1.
  - done is high in cycle k+1+((L-S) mod 256 + 1)*(P+1).
- Boundary conditions:
  - S == L: done on the first tick.
  - L < S: counter wraps through 255->0 before matching.
  - prescale = 0: tick every RUN cycle.
- Priority: an accepted START/PAUSE/STOP in the same cycle as a tick wins. That tick's strobes and done are suppressed.
- ena=0: no command accepted, no tick, pre_cnt frozen, all strobes 0, state held.
- DONE: stays until START or STOP; busy=0.
- cnt_load, cnt_inc and done are Mealy outputs, never asserted together except load+done on an auto-reload match.
- Reset mid-RUN: immediate return to reset state, strobes drop asynchronously.

Decomposition:
- Shared package counter_pkg holds:
  - state enum (5 states, 3 bits);
  - opcode constants OP_SET_LIMIT/OP_START/OP_PAUSE/OP_STOP;
  - CNT_W=8.
- One sub-module: counter_prescaler.
  - Inputs: clk, rst_n, run, clr, prescale.
  - Output: tick.
- FSM and compare logic stay in counter_sequencer.

Test Plan:
- Reset check: reset asserted mid-RUN -> state_o=0, cnt_load=cnt_inc=done=busy=0 immediately; after release SET_LIMIT is not needed, since limit_r=8'hFF.
- SET_LIMIT 5, START 3, P=0, auto_reload=0, START at edge k:
  - cnt_load=1 with val 3 at k+1;
  - cnt_inc at k+2 and k+3;
  - done at k+4;
  - state DONE at k+5, cnt_q stays 5.
- P=2, S=0, L=1: done 7 cycles after acceptance (k+1+2*3). cnt_inc pulses exactly every 3rd RUN cycle.
- auto_reload=1, S=10, L=12, P=0: done every 3 ticks, each with cnt_load val 10; busy stays 1 until STOP -> IDLE.
- Wrap case: S=254, L=1, P=0 -> cnt_inc for 254, 255, 0; done at k+5.
- Collision and enable:
  - PAUSE issued on a tick cycle: no cnt_inc that cycle, state HOLD; resume continues the count.
  - ena=0 for 4 cycles in RUN delays done by exactly 4 cycles; cmd_ready=0 throughout.
